bram_tdp_port_exerciser: RTL
============================

Name: bram_tdp_port_exerciser

Overview:
- Self-contained initiator that drives one port of a true-dual-port block RAM: address, write data, write enable, byte enables and read enable.
- Runs a fixed three-pass sequence: full-word write, byte-enabled partial write, then read-back with compare. It checks the registered read data and reports pass/fail, error count and the first failing address.
- Used to exercise inferred BRAM (split and non-split) in hardware smoke tests and formal/sim benches.

Parameters:
- ADDRWIDTH, 10, port address width
- DEPTH, 1024, number of words exercised (addresses 0..DEPTH-1, DEPTH <= 2**ADDRWIDTH)
- DATAWIDTH, 36, port data width
- BYTEWIDTH, 9, bits per byte-enable lane; DATAWIDTH % BYTEWIDTH == 0; NB = DATAWIDTH/BYTEWIDTH

Ports:
- clk  in  1  single clock; all state and all RAM-port outputs on posedge clk
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a run when accepted
- busy  out  1  high while a run is in progress
- done  out  1  high from run completion until the next accepted start
- pass  out  1  valid when done=1; 1 iff err_count==0
- err_count  out  16  number of mismatching read words, saturates at 16'hFFFF
- err_addr  out  ADDRWIDTH  address of first mismatch; 0 if none
- addr  out  ADDRWIDTH  RAM port address
- wd  out  DATAWIDTH  RAM write data
- we  out  1  RAM write enable
- be  out  NB  RAM byte enables; bit i covers wd[i*BYTEWIDTH +: BYTEWIDTH]
- re  out  1  RAM read enable
- rd  in  DATAWIDTH  RAM registered read data; valid the cycle after re is presented

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: busy, done, pass, err_count, err_addr, addr, wd, we, be, re. Takes effect immediately, including mid-run; the run is abandoned with no completion reported.
- Pattern P(a): byte i = (a + i) mod 2**BYTEWIDTH, for i = 0..NB-1.
- Partial lane L(a) = a mod NB.
- Expected word E(a): P(a) with byte L(a) replaced by ~P(a) byte L(a).
- All RAM-port outputs are registered. we and re are never both 1.
- FSM states: IDLE, WR_FULL, WR_BE, RD, DRAIN, DONE.
- IDLE/DONE:
  - start=1 -> WR_FULL at addr 0; busy=1 and done=0 on the next cycle.
  - start is ignored in all other states.
- WR_FULL: one word per cycle, a=0..DEPTH-1.
  - Outputs: we=1, be=all ones, wd=P(a).
  - After a=DEPTH-1 -> WR_BE, a=0.
- WR_BE: one word per cycle.
  - Outputs: we=1, be=one-hot bit L(a), wd=~P(a) (all lanes driven, only lane L(a) enabled).
  - After a=DEPTH-1 -> RD, a=0.
- RD: one read per cycle, a=0..DEPTH-1, with re=1, we=0, be=0.
  - The expected value E(a) and address a are pipelined one stage.
  - rd is compared in the following cycle.
  - After a=DEPTH-1 -> DRAIN.
- DRAIN (one cycle):
  - re=0; the last compare occurs.
  - -> DONE: busy=0, done=1, pass=(err_count==0).
- Compare:
  - On a mismatch, err_count increments (saturating).
  - On the first mismatch of the run only, err_addr is loaded with the pipelined address.
  - An accepted start clears err_count, err_addr and pass.
- Run length: exactly 3*DEPTH+1 busy cycles.
- Idle outputs: addr, wd, be hold 0 whenever we=0 and re=0.

Test Plan:
- Params ADDRWIDTH=4, DEPTH=16, DATAWIDTH=36, BYTEWIDTH=9 (NB=4); bench uses a behavioural byte-enabled RAM with 1-cycle registered read.
- Scenario 1, reset: hold rst_n=0 with random start/rd -> all outputs 0. Release, no start -> outputs stay 0.
- Scenario 2, clean run: one-cycle start pulse -> busy=1 for exactly 49 cycles, then done=1, pass=1, err_count=0, err_addr=0.
  - Address 5 reads back {byte3=8, byte2=7, byte1=~6=9'h1F9, byte0=5}.
  - we/re never overlap.
- Scenario 3, stuck bit: RAM model forces rd[0]=1 only at address 6 (byte0 expected 6) -> done=1, pass=0, err_count=1, err_addr=6.
- Scenario 4, broken byte enables: RAM model ignores be (writes all lanes) -> all 16 reads mismatch -> err_count=16, err_addr=0, pass=0.
- Scenario 5, start while busy, then reset mid-run:
  - Start pulses while busy are ignored; the run length is still 49.
  - Pulse rst_n low during RD at a=9 -> all outputs 0 asynchronously.
  - A new start then completes with pass=1, err_count=0.

Source files
------------

// File: rtl/bram_tdp_port_exerciser.sv
// Self-running initiator for one port of a true-dual-port BRAM: full-word write pass,
// byte-enabled partial write pass, then read-back with compare against the expected merge.
module bram_tdp_port_exerciser #(
    parameter int ADDRWIDTH = 10,
    parameter int DEPTH     = 1024,
    parameter int DATAWIDTH = 36,
    parameter int BYTEWIDTH = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [15:0]                    err_count,
    output logic [ADDRWIDTH-1:0]           err_addr,
    output logic [ADDRWIDTH-1:0]           addr,
    output logic [DATAWIDTH-1:0]           wd,
    output logic                           we,
    output logic [DATAWIDTH/BYTEWIDTH-1:0] be,
    output logic                           re,
    input  logic [DATAWIDTH-1:0]           rd
);

    localparam int NB = DATAWIDTH / BYTEWIDTH;
    localparam logic [ADDRWIDTH-1:0] LAST_A = ADDRWIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_FULL = 3'd1,
        S_WR_BE   = 3'd2,
        S_RD      = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Byte i of the base pattern is (a + i) mod 2**BYTEWIDTH.
    function automatic logic [DATAWIDTH-1:0] pat_of(input logic [ADDRWIDTH-1:0] a);
        logic [DATAWIDTH-1:0] v;
        v = {DATAWIDTH{1'b0}};
        for (int i = 0; i < NB; i++) begin
            v[i*BYTEWIDTH +: BYTEWIDTH] = BYTEWIDTH'(a) + BYTEWIDTH'(i);
        end
        return v;
    endfunction

    function automatic int lane_of(input logic [ADDRWIDTH-1:0] a);
        return int'(a) % NB;
    endfunction

    function automatic logic [NB-1:0] lane_be(input logic [ADDRWIDTH-1:0] a);
        return NB'(1'b1) << lane_of(a);
    endfunction

    // Word left in RAM after both write passes: base pattern with the partial lane inverted.
    function automatic logic [DATAWIDTH-1:0] exp_of(input logic [ADDRWIDTH-1:0] a);
        logic [DATAWIDTH-1:0] v;
        int l;
        v = pat_of(a);
        l = lane_of(a);
        v[l*BYTEWIDTH +: BYTEWIDTH] = ~v[l*BYTEWIDTH +: BYTEWIDTH];
        return v;
    endfunction

    state_t                 r_state;
    logic [ADDRWIDTH-1:0]   r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [15:0]            r_err_cnt;
    logic [ADDRWIDTH-1:0]   r_err_addr;
    logic [ADDRWIDTH-1:0]   r_addr;
    logic [DATAWIDTH-1:0]   r_wd;
    logic                   r_we;
    logic [NB-1:0]          r_be;
    logic                   r_re;
    logic                   r_cmp_v;
    logic [ADDRWIDTH-1:0]   r_exp_addr;
    logic [DATAWIDTH-1:0]   r_exp;

    state_t                 w_state_nxt;
    logic [ADDRWIDTH-1:0]   w_cnt_nxt;
    logic                   w_start_acc;
    logic [ADDRWIDTH-1:0]   w_addr_nxt;
    logic [DATAWIDTH-1:0]   w_wd_nxt;
    logic                   w_we_nxt;
    logic [NB-1:0]          w_be_nxt;
    logic                   w_re_nxt;
    logic                   w_mismatch;
    logic [15:0]            w_err_cnt_nxt;
    logic [ADDRWIDTH-1:0]   w_err_addr_nxt;
    logic                   w_pass_nxt;

    // Next state and word counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_WR_FULL;
                    w_cnt_nxt   = {ADDRWIDTH{1'b0}};
                    w_start_acc = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WR_FULL: begin
                if (r_cnt == LAST_A) begin
                    w_state_nxt = S_WR_BE;
                    w_cnt_nxt   = {ADDRWIDTH{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + ADDRWIDTH'(1);
                end
            end
            S_WR_BE: begin
                if (r_cnt == LAST_A) begin
                    w_state_nxt = S_RD;
                    w_cnt_nxt   = {ADDRWIDTH{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + ADDRWIDTH'(1);
                end
            end
            S_RD: begin
                if (r_cnt == LAST_A) begin
                    w_state_nxt = S_DRAIN;
                    w_cnt_nxt   = {ADDRWIDTH{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + ADDRWIDTH'(1);
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // RAM-port values for the upcoming cycle, decoded from the next state so they can be registered.
    always_comb begin
        w_addr_nxt = {ADDRWIDTH{1'b0}};
        w_wd_nxt   = {DATAWIDTH{1'b0}};
        w_we_nxt   = 1'b0;
        w_be_nxt   = {NB{1'b0}};
        w_re_nxt   = 1'b0;
        case (w_state_nxt)
            S_WR_FULL: begin
                w_addr_nxt = w_cnt_nxt;
                w_wd_nxt   = pat_of(w_cnt_nxt);
                w_we_nxt   = 1'b1;
                w_be_nxt   = {NB{1'b1}};
            end
            S_WR_BE: begin
                w_addr_nxt = w_cnt_nxt;
                w_wd_nxt   = ~pat_of(w_cnt_nxt);
                w_we_nxt   = 1'b1;
                w_be_nxt   = lane_be(w_cnt_nxt);
            end
            S_RD: begin
                w_addr_nxt = w_cnt_nxt;
                w_re_nxt   = 1'b1;
            end
            default: begin
                w_addr_nxt = {ADDRWIDTH{1'b0}};
            end
        endcase
    end

    // Read-back compare, error bookkeeping and the pass verdict taken on leaving DRAIN.
    always_comb begin
        w_mismatch     = r_cmp_v && (rd != r_exp);
        w_err_cnt_nxt  = r_err_cnt;
        w_err_addr_nxt = r_err_addr;
        if (w_start_acc) begin
            w_err_cnt_nxt  = 16'h0000;
            w_err_addr_nxt = {ADDRWIDTH{1'b0}};
        end else if (w_mismatch) begin
            if (r_err_cnt != 16'hFFFF) begin
                w_err_cnt_nxt = r_err_cnt + 16'h0001;
            end else begin
                w_err_cnt_nxt = r_err_cnt;
            end
            if (r_err_cnt == 16'h0000) begin
                w_err_addr_nxt = r_exp_addr;
            end else begin
                w_err_addr_nxt = r_err_addr;
            end
        end else begin
            w_err_cnt_nxt = r_err_cnt;
        end
        if (w_start_acc) begin
            w_pass_nxt = 1'b0;
        end else if (r_state == S_DRAIN) begin
            w_pass_nxt = (w_err_cnt_nxt == 16'h0000);
        end else begin
            w_pass_nxt = r_pass;
        end
    end

    // State, registered outputs and the one-stage expected-value pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= {ADDRWIDTH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 16'h0000;
            r_err_addr <= {ADDRWIDTH{1'b0}};
            r_addr     <= {ADDRWIDTH{1'b0}};
            r_wd       <= {DATAWIDTH{1'b0}};
            r_we       <= 1'b0;
            r_be       <= {NB{1'b0}};
            r_re       <= 1'b0;
            r_cmp_v    <= 1'b0;
            r_exp_addr <= {ADDRWIDTH{1'b0}};
            r_exp      <= {DATAWIDTH{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= (w_state_nxt == S_WR_FULL) || (w_state_nxt == S_WR_BE) ||
                          (w_state_nxt == S_RD) || (w_state_nxt == S_DRAIN);
            r_done     <= (w_state_nxt == S_DONE);
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_err_addr <= w_err_addr_nxt;
            r_addr     <= w_addr_nxt;
            r_wd       <= w_wd_nxt;
            r_we       <= w_we_nxt;
            r_be       <= w_be_nxt;
            r_re       <= w_re_nxt;
            r_cmp_v    <= r_re;
            r_exp_addr <= r_addr;
            r_exp      <= exp_of(r_addr);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_cnt;
    assign err_addr  = r_err_addr;
    assign addr      = r_addr;
    assign wd        = r_wd;
    assign we        = r_we;
    assign be        = r_be;
    assign re        = r_re;

endmodule
